// File: rtl/npc_seq_ctrl_if.sv
// Fetch / data-memory handshake between the NPC sequencer and its IFU/LSU.
// The sequencer is the requester (master); memories answer with acks (slave).
interface npc_seq_ctrl_if;
    logic        ifu_req;
    logic        ifu_ack;
    logic [31:0] ifu_rdata;
    logic        lsu_req;
    logic        lsu_wen;
    logic        lsu_ack;

    modport master (output ifu_req, lsu_req, lsu_wen,
                    input  ifu_ack, ifu_rdata, lsu_ack);
    modport slave  (input  ifu_req, lsu_req, lsu_wen,
                    output ifu_ack, ifu_rdata, lsu_ack);
endinterface

// File: rtl/npc_seq_ctrl.sv
// Multi-cycle FETCH->DECODE->EXEC->MEM->WB sequencer for the NPC core.
// Moore outputs, sticky HALT/FAULT, handshake timeout and retired-instruction count.
module npc_seq_ctrl #(
    parameter int TIMEOUT = 256,
    parameter int CNT_W   = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    npc_seq_ctrl_if.master   bus,
    output logic [31:0]      inst,
    output logic             inst_valid,
    output logic             pc_we,
    output logic             rf_we,
    output logic             halt,
    output logic             fault,
    output logic [CNT_W-1:0] instret
);
    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        S_RST, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_FAULT
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    logic is_load, is_store, is_branch, is_ebreak, timed_out;
    assign is_load   = (inst[6:0] == OP_LOAD);
    assign is_store  = (inst[6:0] == OP_STORE);
    assign is_branch = (inst[6:0] == OP_BRANCH);
    assign is_ebreak = (inst[6:0] == OP_SYSTEM) && inst[20];
    assign timed_out = (cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_RST;
        else        state <= state_nxt;
    end

    // An ack in the final wait cycle takes priority over the timeout.
    always_comb begin
        state_nxt = state;
        case (state)
            S_RST:    state_nxt = S_FETCH;
            S_FETCH:  if (bus.ifu_ack)  state_nxt = S_DECODE;
                      else if (timed_out) state_nxt = S_FAULT;
            S_DECODE: state_nxt = is_ebreak ? S_HALT : S_EXEC;
            S_EXEC:   state_nxt = (is_load || is_store) ? S_MEM : S_WB;
            S_MEM:    if (bus.lsu_ack)  state_nxt = S_WB;
                      else if (timed_out) state_nxt = S_FAULT;
            S_WB:     state_nxt = S_FETCH;
            S_HALT:   state_nxt = S_HALT;
            S_FAULT:  state_nxt = S_FAULT;
            default:  state_nxt = S_RST;
        endcase
    end

    always_comb begin
        bus.ifu_req = 1'b0;
        bus.lsu_req = 1'b0;
        bus.lsu_wen = 1'b0;
        inst_valid  = 1'b0;
        pc_we       = 1'b0;
        rf_we       = 1'b0;
        halt        = 1'b0;
        fault       = 1'b0;
        case (state)
            S_FETCH:  bus.ifu_req = 1'b1;
            S_DECODE: inst_valid  = 1'b1;
            S_MEM: begin
                bus.lsu_req = 1'b1;
                bus.lsu_wen = is_store;
            end
            S_WB: begin
                pc_we = 1'b1;
                rf_we = !(is_store || is_branch);
            end
            S_HALT:   halt  = 1'b1;
            S_FAULT:  fault = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inst    <= '0;
            instret <= '0;
            cnt     <= '0;
        end else begin
            if (state == S_FETCH && bus.ifu_ack) inst <= bus.ifu_rdata;
            if (state == S_WB) instret <= instret + CNT_W'(1);
            // Only waiting cycles advance the counter, so it is zero on entry to FETCH/MEM.
            if ((state == S_FETCH && !bus.ifu_ack) || (state == S_MEM && !bus.lsu_ack))
                cnt <= cnt + CW'(1);
            else
                cnt <= '0;
        end
    end
endmodule

// File: tb/tb_npc_seq_ctrl.sv
// Directed bench for npc_seq_ctrl (TIMEOUT=8): one task per scenario, inline checks.
module tb_npc_seq_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] inst;
    logic        inst_valid, pc_we, rf_we, halt, fault;
    logic [63:0] instret;
    int          pass = 0, total = 0;

    npc_seq_ctrl_if bus();

    npc_seq_ctrl #(.TIMEOUT(8), .CNT_W(64)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .inst(inst), .inst_valid(inst_valid),
        .pc_we(pc_we), .rf_we(rf_we), .halt(halt), .fault(fault), .instret(instret)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        bus.ifu_ack = 1'b0; bus.lsu_ack = 1'b0; bus.ifu_rdata = 32'h0;
        tick; tick;
        rst_n = 1'b1;
        tick;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        bus.ifu_ack = 1'b0; bus.lsu_ack = 1'b0; bus.ifu_rdata = 32'h0;
        tick; tick;
        total++; if ({bus.ifu_req, bus.lsu_req, bus.lsu_wen, inst_valid, pc_we, rf_we, halt, fault} !== 8'h0)
            $display("FAIL reset_outs got=%b exp=00000000", {bus.ifu_req, bus.lsu_req, bus.lsu_wen, inst_valid, pc_we, rf_we, halt, fault}); else pass++;
        total++; if (instret !== 64'd0) $display("FAIL reset_instret got=%0d exp=0", instret); else pass++;
        total++; if (inst !== 32'h0) $display("FAIL reset_inst got=%h exp=0", inst); else pass++;
        rst_n = 1'b1;
        #1;
        total++; if (bus.ifu_req !== 1'b0) $display("FAIL reset_rst_state got=%b exp=0", bus.ifu_req); else pass++;
        tick;
        total++; if (bus.ifu_req !== 1'b1) $display("FAIL reset_fetch got=%b exp=1", bus.ifu_req); else pass++;
    endtask

    task automatic test_addi;
        bus.ifu_rdata = 32'h00100093; bus.ifu_ack = 1'b1;
        tick;
        bus.ifu_ack = 1'b0; bus.ifu_rdata = 32'hdeadbeef;
        total++; if (inst_valid !== 1'b1 || inst !== 32'h00100093)
            $display("FAIL addi_decode got=%b/%h exp=1/00100093", inst_valid, inst); else pass++;
        total++; if (bus.ifu_req !== 1'b0) $display("FAIL addi_req_drop got=%b exp=0", bus.ifu_req); else pass++;
        tick;
        total++; if ({inst_valid, pc_we, bus.lsu_req} !== 3'b000) $display("FAIL addi_exec got=%b exp=000", {inst_valid, pc_we, bus.lsu_req}); else pass++;
        tick;
        total++; if ({pc_we, rf_we} !== 2'b11 || instret !== 64'd0)
            $display("FAIL addi_wb got=%b/%0d exp=11/0", {pc_we, rf_we}, instret); else pass++;
        tick;
        total++; if (instret !== 64'd1 || bus.ifu_req !== 1'b1 || pc_we !== 1'b0)
            $display("FAIL addi_retire got=%0d/%b/%b exp=1/1/0", instret, bus.ifu_req, pc_we); else pass++;
        total++; if (inst !== 32'h00100093) $display("FAIL addi_inst_hold got=%h exp=00100093", inst); else pass++;
    endtask

    task automatic test_load;
        int req_cycles = 0;
        bus.ifu_rdata = 32'h0000a103; bus.ifu_ack = 1'b1;
        tick;
        bus.ifu_ack = 1'b0;
        tick;
        bus.lsu_ack = 1'b1;
        tick;
        bus.lsu_ack = 1'b0;
        total++; if ({bus.lsu_req, bus.lsu_wen} !== 2'b10) $display("FAIL lw_mem got=%b exp=10", {bus.lsu_req, bus.lsu_wen}); else pass++;
        for (int i = 0; i < 3; i++) begin
            if (bus.lsu_req) req_cycles++;
            if (i == 2) bus.lsu_ack = 1'b1;
            tick;
        end
        bus.lsu_ack = 1'b0;
        total++; if (req_cycles !== 3) $display("FAIL lw_req_cycles got=%0d exp=3", req_cycles); else pass++;
        total++; if ({pc_we, rf_we, bus.lsu_req} !== 3'b110) $display("FAIL lw_wb got=%b exp=110", {pc_we, rf_we, bus.lsu_req}); else pass++;
        tick;
        total++; if (instret !== 64'd2 || bus.ifu_req !== 1'b1) $display("FAIL lw_retire got=%0d/%b exp=2/1", instret, bus.ifu_req); else pass++;
    endtask

    task automatic test_store_branch;
        bus.ifu_rdata = 32'h0020a023; bus.ifu_ack = 1'b1;
        tick;
        bus.ifu_ack = 1'b0;
        tick; tick;
        total++; if ({bus.lsu_req, bus.lsu_wen} !== 2'b11) $display("FAIL sw_mem got=%b exp=11", {bus.lsu_req, bus.lsu_wen}); else pass++;
        bus.lsu_ack = 1'b1;
        tick;
        bus.lsu_ack = 1'b0;
        total++; if ({pc_we, rf_we, bus.lsu_wen} !== 3'b100) $display("FAIL sw_wb got=%b exp=100", {pc_we, rf_we, bus.lsu_wen}); else pass++;
        tick;
        total++; if (instret !== 64'd3) $display("FAIL sw_retire got=%0d exp=3", instret); else pass++;
        bus.ifu_rdata = 32'h00000063; bus.ifu_ack = 1'b1;
        tick;
        bus.ifu_ack = 1'b0;
        tick;
        total++; if (bus.lsu_req !== 1'b0) $display("FAIL beq_exec_no_mem got=%b exp=0", bus.lsu_req); else pass++;
        tick;
        total++; if ({pc_we, rf_we} !== 2'b10) $display("FAIL beq_wb got=%b exp=10", {pc_we, rf_we}); else pass++;
        tick;
        total++; if (instret !== 64'd4) $display("FAIL beq_retire got=%0d exp=4", instret); else pass++;
    endtask

    task automatic test_timeout_edge;
        for (int i = 0; i < 7; i++) tick;
        total++; if (bus.ifu_req !== 1'b1 || fault !== 1'b0) $display("FAIL tmo_edge_wait got=%b/%b exp=1/0", bus.ifu_req, fault); else pass++;
        bus.ifu_rdata = 32'h00100093; bus.ifu_ack = 1'b1;
        tick;
        bus.ifu_ack = 1'b0;
        total++; if (inst_valid !== 1'b1 || fault !== 1'b0) $display("FAIL tmo_edge_ack_wins got=%b/%b exp=1/0", inst_valid, fault); else pass++;
        tick; tick; tick;
        total++; if (instret !== 64'd5) $display("FAIL tmo_edge_retire got=%0d exp=5", instret); else pass++;
    endtask

    task automatic test_ebreak;
        int ok = 0;
        bus.ifu_rdata = 32'h00000073; bus.ifu_ack = 1'b1;
        tick;
        bus.ifu_ack = 1'b0;
        tick;
        total++; if (halt !== 1'b0) $display("FAIL ecall_no_halt got=%b exp=0", halt); else pass++;
        tick;
        total++; if ({pc_we, rf_we} !== 2'b11) $display("FAIL ecall_wb got=%b exp=11", {pc_we, rf_we}); else pass++;
        tick;
        bus.ifu_rdata = 32'h00100073; bus.ifu_ack = 1'b1;
        tick;
        bus.ifu_ack = 1'b0;
        total++; if (inst_valid !== 1'b1) $display("FAIL ebreak_decode got=%b exp=1", inst_valid); else pass++;
        tick;
        bus.ifu_rdata = 32'h0;
        for (int i = 0; i < 20; i++) begin
            bus.ifu_ack = 1'b1; bus.lsu_ack = 1'b1;
            if (halt === 1'b1 && fault === 1'b0 && bus.ifu_req === 1'b0 && bus.lsu_req === 1'b0 &&
                pc_we === 1'b0 && rf_we === 1'b0 && instret === 64'd6) ok++;
            tick;
        end
        bus.ifu_ack = 1'b0; bus.lsu_ack = 1'b0;
        total++; if (ok !== 20) $display("FAIL ebreak_halt_hold got=%0d exp=20 cycles", ok); else pass++;
        total++; if (inst !== 32'h00100073) $display("FAIL ebreak_inst_hold got=%h exp=00100073", inst); else pass++;
    endtask

    task automatic test_timeout_fault;
        int req_cycles = 0;
        do_reset;
        for (int i = 0; i < 20 && fault !== 1'b1; i++) begin
            if (bus.ifu_req) req_cycles++;
            tick;
        end
        total++; if (req_cycles !== 8) $display("FAIL tmo_req_cycles got=%0d exp=8", req_cycles); else pass++;
        total++; if ({fault, halt, bus.ifu_req} !== 3'b100) $display("FAIL tmo_fault got=%b exp=100", {fault, halt, bus.ifu_req}); else pass++;
        bus.ifu_ack = 1'b1;
        tick; tick; tick;
        bus.ifu_ack = 1'b0;
        total++; if ({fault, inst_valid, bus.ifu_req, instret != 64'd0} !== 4'b1000)
            $display("FAIL tmo_sticky got=%b exp=1000", {fault, inst_valid, bus.ifu_req, instret != 64'd0}); else pass++;
    endtask

    task automatic test_reset_mid_mem;
        do_reset;
        bus.ifu_rdata = 32'h00100093; bus.ifu_ack = 1'b1;
        tick;
        bus.ifu_ack = 1'b0;
        tick; tick; tick;
        bus.ifu_rdata = 32'h0000a103; bus.ifu_ack = 1'b1;
        tick;
        bus.ifu_ack = 1'b0;
        tick; tick;
        total++; if (bus.lsu_req !== 1'b1 || instret !== 64'd1) $display("FAIL rst_mem_setup got=%b/%0d exp=1/1", bus.lsu_req, instret); else pass++;
        #2 rst_n = 1'b0;
        #1;
        total++; if ({bus.lsu_req, pc_we, rf_we} !== 3'b000 || instret !== 64'd0)
            $display("FAIL rst_mem_async got=%b/%0d exp=000/0", {bus.lsu_req, pc_we, rf_we}, instret); else pass++;
        tick;
        rst_n = 1'b1;
        #1;
        total++; if (bus.ifu_req !== 1'b0) $display("FAIL rst_mem_first_clk got=%b exp=0", bus.ifu_req); else pass++;
        tick;
        total++; if (bus.ifu_req !== 1'b1) $display("FAIL rst_mem_fetch got=%b exp=1", bus.ifu_req); else pass++;
    endtask

    initial begin
        rst_n = 1'b0;
        bus.ifu_ack = 1'b0; bus.lsu_ack = 1'b0; bus.ifu_rdata = 32'h0;
        tick;
        test_reset;
        test_addi;
        test_load;
        test_store_branch;
        test_timeout_edge;
        test_ebreak;
        test_timeout_fault;
        test_reset_mid_mem;
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
